// File: rtl/fq_ingress.sv
// Per-flow ingress classifier: decodes packet headers and steers each packet into its channel FIFO.
// Optional macro FQ_INGRESS_DROP_EN discards packets whose target FIFO is full at header time.
module fq_ingress #(
    parameter int NUM_IN_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        fifo_wrreq [2**NUM_IN_LOG2],
    output logic [63:0] fifo_data  [2**NUM_IN_LOG2],
    input  logic        fifo_full  [2**NUM_IN_LOG2],
    output logic [15:0] drop_count,
    output logic        busy
);
    localparam int N = 2**NUM_IN_LOG2;

    typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

    state_t                 state_reg;
    logic [7:0]             remaining_reg;
    logic [NUM_IN_LOG2-1:0] cur_reg;

    logic [NUM_IN_LOG2-1:0] hdr_ch;
    logic [7:0]             hdr_len;
    logic                   hdr_full;
    logic                   hdr_drop;
    logic                   accept;
    logic                   do_write;
    logic [NUM_IN_LOG2-1:0] wr_ch;

    assign hdr_ch   = in_data[8 +: NUM_IN_LOG2];
    assign hdr_len  = (in_data[7:0] == 8'd0) ? 8'd1 : in_data[7:0];
    assign hdr_full = fifo_full[hdr_ch];

`ifdef FQ_INGRESS_DROP_EN
    assign hdr_drop = hdr_full;
`else
    assign hdr_drop = 1'b0;
`endif

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state_reg)
`ifdef FQ_INGRESS_DROP_EN
                IDLE:    in_ready = 1'b1;
`else
                IDLE:    in_ready = !hdr_full;
`endif
                BODY:    in_ready = !fifo_full[cur_reg];
                DROP:    in_ready = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept   = in_valid && in_ready;
    assign do_write = accept && ((state_reg == BODY) || (state_reg == IDLE && !hdr_drop));
    assign wr_ch    = (state_reg == BODY) ? cur_reg : hdr_ch;
    assign busy     = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            remaining_reg <= 8'd0;
            cur_reg       <= '0;
        end else if (accept) begin
            case (state_reg)
                IDLE: begin
                    if (hdr_len > 8'd1) begin
                        remaining_reg <= hdr_len - 8'd1;
                        cur_reg       <= hdr_ch;
                        state_reg     <= hdr_drop ? DROP : BODY;
                    end
                end
                BODY, DROP: begin
                    // Last word returns to IDLE on the same edge, so the next word is a header.
                    if (remaining_reg != 8'd0) begin
                        remaining_reg <= remaining_reg - 8'd1;
                    end
                    if (remaining_reg <= 8'd1) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef FQ_INGRESS_DROP_EN
    logic [15:0] drop_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_reg <= 16'd0;
        end else if (accept && state_reg == IDLE && hdr_drop && drop_count_reg != 16'hFFFF) begin
            drop_count_reg <= drop_count_reg + 16'd1;
        end
    end

    assign drop_count = drop_count_reg;
`else
    assign drop_count = 16'd0;
`endif

    // Per-channel write registers; data holds its last value when the channel is not written.
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        logic sel;
        assign sel = do_write && (wr_ch == NUM_IN_LOG2'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                fifo_wrreq[gi] <= 1'b0;
                fifo_data[gi]  <= 64'd0;
            end else begin
                fifo_wrreq[gi] <= sel;
                if (sel) begin
                    fifo_data[gi] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fq_ingress.sv
// Randomized self-checking bench for fq_ingress against a packet-level reference model.
// Expectations follow FQ_INGRESS_DROP_EN when the bench is built with that macro.
module tb_fq_ingress;
    localparam int L = 3;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        fifo_wrreq [N];
    logic [63:0] fifo_data  [N];
    logic        fifo_full  [N];
    logic [15:0] drop_count;
    logic        busy;

    fq_ingress #(.NUM_IN_LOG2(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .fifo_wrreq (fifo_wrreq),
        .fifo_data  (fifo_data),
        .fifo_full  (fifo_full),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

`ifdef FQ_INGRESS_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit verbose  = 1'b1;

    // Reference model: words still owed by the current packet, its channel, and whether it is discarded.
    int          left = 0;
    int          pkt_ch = 0;
    bit          pkt_drop = 1'b0;
    logic [7:0]  exp_wr;
    logic [63:0] exp_data [N];
    int          exp_drop = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        if (rst) return 1'b0;
        if (left == 0) return DROP_EN ? 1'b1 : !fifo_full[in_data[10:8]];
        if (pkt_drop) return 1'b1;
        return !fifo_full[pkt_ch];
    endfunction

    function automatic logic [63:0] hdr(input int ch, input int len);
        logic [63:0] w;
        w = {$urandom, $urandom};
        w[10:8] = ch[2:0];
        w[7:0]  = len[7:0];
        return w;
    endfunction

    // One clock: inputs already driven; check ready, advance model, check registered outputs.
    task automatic cycle(output bit acc);
        bit   rdy;
        int   len;
        int   ch;
        logic [7:0] got_wr;
        #1;
        rdy = model_ready();
        check("in_ready", in_ready, rdy);
        acc = in_valid && rdy;
        exp_wr = '0;
        if (rst) begin
            left = 0;
            pkt_drop = 1'b0;
            exp_drop = 0;
            for (int i = 0; i < N; i++) exp_data[i] = '0;
        end else if (acc) begin
            if (left == 0) begin
                len = (in_data[7:0] == 8'd0) ? 1 : int'(in_data[7:0]);
                ch = int'(in_data[10:8]);
                pkt_ch = ch;
                pkt_drop = DROP_EN && fifo_full[ch];
                left = len - 1;
                if (pkt_drop) begin
                    if (exp_drop < 65535) exp_drop++;
                end else begin
                    exp_wr[ch] = 1'b1;
                    exp_data[ch] = in_data;
                end
            end else begin
                left--;
                if (!pkt_drop) begin
                    exp_wr[pkt_ch] = 1'b1;
                    exp_data[pkt_ch] = in_data;
                end
            end
            if (verbose)
                $display("t=%0t accept word=%h ch=%0d left=%0d drop=%0b", $time, in_data, pkt_ch, left, pkt_drop);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) got_wr[i] = fifo_wrreq[i];
        check("wrreq", got_wr, exp_wr);
        for (int i = 0; i < N; i++) check($sformatf("data%0d", i), fifo_data[i], exp_data[i]);
        check("busy", busy, left != 0);
        check("drop_count", drop_count, exp_drop);
    endtask

    task automatic send_word(input logic [63:0] w);
        bit acc;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = w;
        do begin
            cycle(acc);
            n++;
        end while (!acc && n < 50);
        check("send_timeout", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    initial begin
        bit acc;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        exp_wr = '0;
        for (int i = 0; i < N; i++) begin
            fifo_full[i] = 1'b0;
            exp_data[i] = '0;
        end
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(1);

        // Header ch2 len3 plus two body words back-to-back.
        send_word(hdr(2, 3));
        send_word({$urandom, $urandom});
        send_word({$urandom, $urandom});
        idle_cycles(1);

        // Back-to-back packets, len 0 is a single word.
        send_word(hdr(5, 1));
        send_word(hdr(0, 2));
        send_word({$urandom, $urandom});
        send_word(hdr(7, 0));
        idle_cycles(1);

        // Backpressure mid-packet on ch3.
        send_word(hdr(3, 4));
        send_word({$urandom, $urandom});
        fifo_full[3] = 1'b1;
        in_valid = 1'b1;
        in_data = {$urandom, $urandom};
        idle_cycles(3);
        fifo_full[3] = 1'b0;
        send_word(in_data);
        send_word({$urandom, $urandom});
        idle_cycles(1);

        // Header to a full channel: dropped with the macro, stalled without it.
        fifo_full[1] = 1'b1;
        in_valid = 1'b1;
        in_data = hdr(1, 5);
        if (!DROP_EN) begin
            idle_cycles(3);
            fifo_full[1] = 1'b0;
        end
        send_word(in_data);
        for (int i = 0; i < 4; i++) send_word({$urandom, $urandom});
        fifo_full[1] = 1'b0;
        send_word(hdr(4, 2));
        send_word({$urandom, $urandom});
        idle_cycles(1);

        // Reset mid-packet: next word after reset is a header.
        send_word(hdr(2, 6));
        send_word({$urandom, $urandom});
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = {$urandom, $urandom};
        cycle(acc);
        rst = 1'b0;
        send_word(hdr(6, 1));
        idle_cycles(1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = {$urandom, $urandom};
            in_data[7:0] = 8'($urandom_range(0, 5));
            for (int c = 0; c < N; c++) fifo_full[c] = ($urandom_range(0, 4) == 0);
            cycle(acc);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < N; c++) fifo_full[c] = 1'b0;
        idle_cycles(8);

        // Drop counter saturation.
        verbose = 1'b0;
        if (DROP_EN) begin
            fifo_full[0] = 1'b1;
            in_valid = 1'b1;
            in_data = hdr(0, 1);
            for (int i = 0; i < 65540; i++) cycle(acc);
            in_valid = 1'b0;
            fifo_full[0] = 1'b0;
            check("drop_sat", drop_count, 16'hFFFF);
        end else begin
            check("drop_tied", drop_count, 16'h0000);
        end
        verbose = 1'b1;
        send_word(hdr(4, 1));
        idle_cycles(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
